core_sequencer: RTL
===================

// Module: core_sequencer
// PURPOSE
//  Multi-cycle control FSM for the rv32i core.
//  - Sequences fetch, decode, execute, memory and writeback around the instruction decoder and ALU.
//  - Owns the PC and drives the IR latch, register-file write and imem/dmem request handshakes.
//  - Uses the decoder's mem_op / wb_from / r_we outputs from rv32i:: to select the path taken.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC value loaded on reset.
//  MEM_TIMEOUT  255            Max wait cycles for imem_ack/dmem_ack before FAULT (1..65535).
// PORTS
//  clk          in   1   core clock; all state changes on its rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  run          in   1   1 = execute; 0 = stop at next instruction boundary
//  pc           out  32  current PC; also the imem address
//  imem_req     out  1   instruction fetch request
//  imem_ack     in   1   fetch data valid this cycle
//  ir_we        out  1   latch the instruction register (1-cycle pulse)
//  mem_op       in   2   rv32i::mem_op_e from decoder
//  wb_from      in   2   rv32i::wb_from_e from decoder
//  r_we         in   1   rv32i::reg_we_e from decoder
//  alu_result   in   32  ALU output: jump target or data address
//  branch_taken in   1   ALU compare result for BTYPE
//  dmem_req     out  1   data memory request
//  dmem_we      out  1   1 = store, 0 = load; valid while dmem_req=1
//  dmem_ack     in   1   data access complete this cycle
//  rf_we        out  1   register-file write strobe (1-cycle pulse)
//  fault        out  1   sticky memory-timeout flag
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=HALT, pc=RESET_PC, all outputs 0, wait counter=0.
//    Reset mid-access drops imem_req/dmem_req immediately.
//  - Output decode: all outputs are Moore decodes of state, except ir_we and rf_we, which are
//    registered 1-cycle pulses.
//  - HALT: run=1 -> FETCH; otherwise stay.
//  - FETCH: imem_req=1 held until imem_ack.
//    On ack: ir_we=1 next cycle, go to DECODE.
//  - DECODE: 1 cycle for decoder and register-file read; go to EXEC.
//  - EXEC: 1 cycle.
//    If mem_op==MEM_STORE or wb_from==WB_MEM -> MEM; else -> WB.
//  - MEM: dmem_req=1 and dmem_we=(mem_op==MEM_STORE), held stable until dmem_ack; then -> WB.
//  - WB (1 cycle), register write:
//    rf_we = (r_we==REG_WE) && (wb_from!=WB_NONE).
//    Stores carry REG_WE but WB_NONE, so they never write.
//  - WB, PC update:
//    Jump (wb_from==WB_PC && r_we==REG_WE): pc <= {alu_result[31:1],1'b0}.
//    Branch (wb_from==WB_PC && r_we==REG_WD): if branch_taken, pc <= {alu_result[31:1],1'b0};
//    else pc <= pc+4.
//    All others: pc <= pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
//  - WB exit: run=1 -> FETCH; run=0 -> HALT.
//  - run is sampled only in HALT and WB; deasserting it mid-instruction completes the instruction.
//  - Latency at 1-cycle ack: ALU op = 4 cycles (FETCH, DECODE, EXEC, WB); load/store = 5.
//  - Wait counter:
//    Counts cycles with an unacked request in FETCH or MEM; cleared on every state change.
//    Reaching MEM_TIMEOUT -> FAULT state.
//    Ack in the same cycle the count reaches the limit: the ack wins, no fault.
//  - FAULT: fault=1, all strobes and requests 0, pc frozen. Exit only via reset.
//  - Acks arriving outside FETCH (imem) or MEM (dmem) are ignored.
// CONFIGURATION
//  - PERF_CNT_EN defined adds two outputs:
//    cycle_cnt out 32: increments every cycle outside HALT and FAULT.
//    instret_cnt out 32: increments on every WB cycle.
//    Both reset to 0 and wrap at 2^32.
//  - PERF_CNT_EN undefined: these ports and counters do not exist.
// TESTING
//  - ADDI at RESET_PC, run=1, acks in 1 cycle -> ir_we, then rf_we 4 cycles after FETCH entry;
//    pc=0x4.
//  - LW with dmem_ack delayed 3 cycles -> dmem_req=1, dmem_we=0 held stable 4 cycles;
//    rf_we once; pc+4.
//  - SW -> dmem_we=1, rf_we stays 0.
//    BEQ taken with alu_result=0x100 -> pc=0x100.
//    BEQ not taken -> pc+4.
//  - JALR with alu_result=0x203 -> pc=0x202 and rf_we=1.
//    pc=0xFFFF_FFFC ALU op -> pc wraps to 0.
//  - imem_ack withheld for MEM_TIMEOUT cycles -> fault=1, imem_req=0;
//    ack on the limit cycle -> no fault.
//    reset_n=0 mid-MEM -> dmem_req=0 asynchronously.
//  - run=0 during EXEC -> instruction retires, then HALT.
//    With PERF_CNT_EN: instret_cnt=1 and cycle_cnt=4 after one ALU op.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the rv32i core.
// Walks HALT -> FETCH -> DECODE -> EXEC -> [MEM] -> WB, owns the PC, and
// drives the imem/dmem request handshakes, the IR latch and the register-file
// write strobe. A request left unacknowledged for MEM_TIMEOUT cycles parks the
// core in FAULT until reset.
// Optional build macro: PERF_CNT_EN adds the cycle_cnt / instret_cnt outputs.

module core_sequencer #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        run,
   output logic [31:0] pc,
   output logic        imem_req,
   input  logic        imem_ack,
   output logic        ir_we,
   input  logic [1:0]  mem_op,
   input  logic [1:0]  wb_from,
   input  logic        r_we,
   input  logic [31:0] alu_result,
   input  logic        branch_taken,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        rf_we,
   output logic        fault
`ifdef PERF_CNT_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
`endif
);

   // Decoder encodings (rv32i::mem_op_e / wb_from_e / reg_we_e).
   localparam logic [1:0] MEM_STORE = 2'd2;
   localparam logic [1:0] WB_NONE   = 2'd0;
   localparam logic [1:0] WB_MEM    = 2'd2;
   localparam logic [1:0] WB_PC     = 2'd3;
   localparam logic       REG_WD    = 1'b0;
   localparam logic       REG_WE    = 1'b1;

   // Last wait-count value before the limit is reached.
   localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      HALT   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      FAULT  = 3'd6
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [15:0] wait_q, wait_d;
   logic        store_q, store_d;
   logic        ir_we_q, ir_we_d;
   logic        rf_we_q, rf_we_d;
   logic        redirect;
   logic [31:0] target;

`ifdef PERF_CNT_EN
   logic [31:0] cycle_q, cycle_d;
   logic [31:0] instret_q, instret_d;
`endif

   // State register: FSM state, PC, wait counter, store flag and pulse flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= HALT;
         pc_q    <= RESET_PC;
         wait_q  <= '0;
         store_q <= 1'b0;
         ir_we_q <= 1'b0;
         rf_we_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         wait_q  <= wait_d;
         store_q <= store_d;
         ir_we_q <= ir_we_d;
         rf_we_q <= rf_we_d;
      end
   end

   // Branch/jump target with bit 0 forced low; redirect selects it in WB.
   always_comb begin
      target   = alu_result & 32'hFFFF_FFFE;
      redirect = 1'b0;
      if (wb_from == WB_PC) begin
         if (r_we == REG_WE) begin
            redirect = 1'b1;
         end else if (r_we == REG_WD) begin
            redirect = branch_taken;
         end
      end
   end

   // Next-state logic, PC update, wait counter and pulse generation.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      wait_d  = wait_q;
      store_d = store_q;
      ir_we_d = 1'b0;
      rf_we_d = 1'b0;

      case (state_q)
         HALT: begin
            if (run) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            // An ack on the limit cycle is checked first so it wins over the timeout.
            if (imem_ack) begin
               state_d = DECODE;
               ir_we_d = 1'b1;
            end else if (wait_q == WAIT_LAST) begin
               state_d = FAULT;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         DECODE: begin
            state_d = EXEC;
         end
         EXEC: begin
            // The store flag is captured here so dmem_we stays a pure state decode in MEM.
            store_d = (mem_op == MEM_STORE);
            if ((mem_op == MEM_STORE) || (wb_from == WB_MEM)) begin
               state_d = MEM;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            if (dmem_ack) begin
               state_d = WB;
            end else if (wait_q == WAIT_LAST) begin
               state_d = FAULT;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         WB: begin
            rf_we_d = (r_we == REG_WE) && (wb_from != WB_NONE);
            pc_d    = redirect ? target : (pc_q + 32'd4);
            state_d = run ? FETCH : HALT;
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = HALT;
         end
      endcase

      if (state_d != state_q) begin
         wait_d = '0;
      end
   end

   // Moore output decode of the current state plus the registered pulses.
   always_comb begin
      pc       = pc_q;
      imem_req = (state_q == FETCH);
      dmem_req = (state_q == MEM);
      dmem_we  = (state_q == MEM) && store_q;
      fault    = (state_q == FAULT);
      ir_we    = ir_we_q;
      rf_we    = rf_we_q;
   end

`ifdef PERF_CNT_EN
   // Performance counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
      end
   end

   // Active cycles exclude HALT and FAULT; every WB cycle retires one instruction.
   always_comb begin
      cycle_d   = cycle_q;
      instret_d = instret_q;
      if ((state_q != HALT) && (state_q != FAULT)) begin
         cycle_d = cycle_q + 32'd1;
      end
      if (state_q == WB) begin
         instret_d = instret_q + 32'd1;
      end
   end

   // Counter outputs.
   always_comb begin
      cycle_cnt   = cycle_q;
      instret_cnt = instret_q;
   end
`endif

endmodule
